// File: rtl/press_classifier.sv
// press_classifier: turns a debounced key level into Morse dot/dash/gap pulses.
// Press and release lengths are measured in Tick periods by one shared counter.
// Ports:
//   Clk, Reset   - clock, asynchronous active-high reset
//   Start        - enable; low forces IDLE and clears the counter
//   Key          - debounced key level (high = pressed), synchronous to Clk
//   Tick         - one-cycle timebase pulse
//   S, L         - one-cycle dot / dash pulses
//   Gap          - one-cycle end-of-letter pulse
//   Abort        - one-cycle stuck-key pulse
//   Busy         - high whenever the FSM is not IDLE
//   PressCnt     - length in ticks of the last completed press
module press_classifier #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned DASH_TICKS = 200,
  parameter int unsigned GAP_TICKS  = 400,
  parameter int unsigned HOLD_MAX   = 2000
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Key,
  input  logic             Tick,
  output logic             S,
  output logic             L,
  output logic             Gap,
  output logic             Abort,
  output logic             Busy,
  output logic [CNT_W-1:0] PressCnt
);

  localparam logic [CNT_W-1:0] DASH_C = CNT_W'(DASH_TICKS);
  localparam logic [CNT_W-1:0] GAP_C  = CNT_W'(GAP_TICKS);
  localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_MAX);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    PRESS = 4'b0010,
    GAP   = 4'b0100,
    STUCK = 4'b1000
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
  logic             key_d_q;
  logic             s_q, s_d, l_q, l_d, gap_q, gap_d, abort_q, abort_d, busy_q, busy_d;
  logic             rise, fall;
  logic [CNT_W-1:0] cnt_inc;

  assign rise = Key & ~key_d_q;
  assign fall = ~Key & key_d_q;

  // Saturating tick counter; all decisions below look at cnt_q (pre-increment).
  assign cnt_inc = (Tick && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

  // Next-state and next-output logic; edges take priority over thresholds.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_inc;
    press_cnt_d = press_cnt_q;
    s_d         = 1'b0;
    l_d         = 1'b0;
    gap_d       = 1'b0;
    abort_d     = 1'b0;

    if (!Start) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (rise) state_d = PRESS;
        end
        PRESS: begin
          if (fall) begin
            if (cnt_q >= DASH_C) l_d = 1'b1;
            else                 s_d = 1'b1;
            press_cnt_d = cnt_q;
            cnt_d       = '0;
            state_d     = GAP;
          end else if (cnt_q >= HOLD_C) begin
            abort_d = 1'b1;
            state_d = STUCK;
          end
        end
        GAP: begin
          if (rise) begin
            cnt_d   = '0;
            state_d = PRESS;
          end else if (cnt_q >= GAP_C) begin
            gap_d   = 1'b1;
            state_d = IDLE;
          end
        end
        STUCK: begin
          if (fall) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Busy is registered from the next state so it tracks state_q exactly.
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      press_cnt_q <= '0;
      key_d_q     <= 1'b0;
      s_q         <= 1'b0;
      l_q         <= 1'b0;
      gap_q       <= 1'b0;
      abort_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      press_cnt_q <= press_cnt_d;
      key_d_q     <= Key;
      s_q         <= s_d;
      l_q         <= l_d;
      gap_q       <= gap_d;
      abort_q     <= abort_d;
      busy_q      <= busy_d;
    end
  end

  assign S        = s_q;
  assign L        = l_q;
  assign Gap      = gap_q;
  assign Abort    = abort_q;
  assign Busy     = busy_q;
  assign PressCnt = press_cnt_q;

endmodule

// File: tb/tb_press_classifier.sv
// tb_press_classifier: directed self-checking bench for press_classifier.
// Small thresholds (dash 3, gap 5, hold 10) with a Tick every 4 cycles.
module tb_press_classifier;

  localparam int unsigned CNT_W = 16;

  logic             Clk;
  logic             Reset;
  logic             Start;
  logic             Key;
  logic             Tick;
  logic             S;
  logic             L;
  logic             Gap;
  logic             Abort;
  logic             Busy;
  logic [CNT_W-1:0] PressCnt;

  int checks = 0;
  int errors = 0;
  int n_s    = 0;
  int n_l    = 0;
  int n_gap  = 0;
  int n_ab   = 0;
  int excl_viol = 0;

  press_classifier #(
    .CNT_W      (CNT_W),
    .DASH_TICKS (3),
    .GAP_TICKS  (5),
    .HOLD_MAX   (10)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .Key      (Key),
    .Tick     (Tick),
    .S        (S),
    .L        (L),
    .Gap      (Gap),
    .Abort    (Abort),
    .Busy     (Busy),
    .PressCnt (PressCnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n cycles; sample 1 time unit after each rising edge and tally pulses.
  task automatic clk(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
      n_s   += int'(S);
      n_l   += int'(L);
      n_gap += int'(Gap);
      n_ab  += int'(Abort);
      if ($countones({S, L, Gap, Abort}) > 1) excl_viol++;
    end
  endtask

  // n tick periods: three quiet cycles, then one cycle with Tick high.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      Tick = 1'b0;
      clk(3);
      Tick = 1'b1;
      clk(1);
      Tick = 1'b0;
    end
  endtask

  task automatic clr();
    n_s   = 0;
    n_l   = 0;
    n_gap = 0;
    n_ab  = 0;
  endtask

  initial begin
    Reset = 1'b1;
    Start = 1'b1;
    Key   = 1'b0;
    Tick  = 1'b0;
    clk(2);
    check("rst_S",        32'(S),        32'd0);
    check("rst_L",        32'(L),        32'd0);
    check("rst_Gap",      32'(Gap),      32'd0);
    check("rst_Abort",    32'(Abort),    32'd0);
    check("rst_Busy",     32'(Busy),     32'd0);
    check("rst_PressCnt", 32'(PressCnt), 32'd0);
    Reset = 1'b0;
    clk(1);

    // Dot: 2-tick press, S one cycle after release, Gap after 5 ticks of release.
    clr();
    Key = 1'b1;
    ticks(2);
    check("dot_busy_press", 32'(Busy), 32'd1);
    Key = 1'b0;
    clk(1);
    check("dot_S",        32'(S),        32'd1);
    check("dot_L",        32'(L),        32'd0);
    check("dot_PressCnt", 32'(PressCnt), 32'd2);
    clk(1);
    check("dot_S_width",  32'(S),        32'd0);
    ticks(5);
    check("dot_no_gap_early", 32'(n_gap), 32'd0);
    clk(1);
    check("dot_Gap",      32'(Gap),      32'd1);
    check("dot_busy_end", 32'(Busy),     32'd0);
    clk(1);
    check("dot_Gap_width", 32'(Gap),     32'd0);
    check("dot_n_s",      32'(n_s),      32'd1);
    check("dot_n_gap",    32'(n_gap),    32'd1);

    // Dash at exactly the threshold.
    clr();
    Key = 1'b1;
    ticks(3);
    Key = 1'b0;
    clk(1);
    check("dash3_L",        32'(L),        32'd1);
    check("dash3_S",        32'(S),        32'd0);
    check("dash3_PressCnt", 32'(PressCnt), 32'd3);
    ticks(6);
    check("dash3_n_gap", 32'(n_gap), 32'd1);
    check("dash3_busy",  32'(Busy),  32'd0);

    // Release on the cycle cnt reaches HOLD_MAX: edge wins, dash, no Abort.
    clr();
    Key = 1'b1;
    ticks(10);
    Key = 1'b0;
    clk(1);
    check("dash10_L",        32'(L),        32'd1);
    check("dash10_Abort",    32'(Abort),    32'd0);
    check("dash10_PressCnt", 32'(PressCnt), 32'd10);
    ticks(6);
    check("dash10_n_ab",  32'(n_ab),  32'd0);
    check("dash10_n_gap", 32'(n_gap), 32'd1);

    // Letter: dot, 2-tick release, dash, long release -> single Gap at the end.
    clr();
    Key = 1'b1;
    ticks(1);
    Key = 1'b0;
    clk(1);
    check("let_S", 32'(S), 32'd1);
    ticks(2);
    Key = 1'b1;
    ticks(3);
    Key = 1'b0;
    clk(1);
    check("let_L",         32'(L),     32'd1);
    check("let_gap_early", 32'(n_gap), 32'd0);
    ticks(6);
    check("let_n_s",   32'(n_s),   32'd1);
    check("let_n_l",   32'(n_l),   32'd1);
    check("let_n_gap", 32'(n_gap), 32'd1);

    // Rise on the cycle cnt reaches GAP_TICKS: edge wins, no Gap.
    clr();
    Key = 1'b1;
    ticks(1);
    Key = 1'b0;
    clk(1);
    ticks(5);
    Key = 1'b1;
    clk(1);
    check("gprio_Gap",  32'(Gap),  32'd0);
    check("gprio_Busy", 32'(Busy), 32'd1);
    ticks(1);
    Key = 1'b0;
    clk(1);
    check("gprio_S", 32'(S), 32'd1);
    ticks(6);
    check("gprio_n_s",   32'(n_s),   32'd2);
    check("gprio_n_gap", 32'(n_gap), 32'd1);

    // Stuck key: Abort one cycle after cnt reaches 10, silent release.
    clr();
    Key = 1'b1;
    ticks(10);
    check("stuck_no_abort_early", 32'(n_ab), 32'd0);
    clk(1);
    check("stuck_Abort", 32'(Abort), 32'd1);
    check("stuck_busy",  32'(Busy),  32'd1);
    clk(1);
    check("stuck_Abort_width", 32'(Abort), 32'd0);
    ticks(2);
    Key = 1'b0;
    clk(1);
    check("stuck_busy_release", 32'(Busy), 32'd0);
    ticks(6);
    check("stuck_n_s",   32'(n_s),   32'd0);
    check("stuck_n_l",   32'(n_l),   32'd0);
    check("stuck_n_gap", 32'(n_gap), 32'd0);
    check("stuck_n_ab",  32'(n_ab),  32'd1);

    // Reset mid-press at cnt = 2, released with Key low.
    clr();
    Key = 1'b1;
    ticks(2);
    Reset = 1'b1;
    #1;
    check("rmid_busy_async", 32'(Busy), 32'd0);
    Key = 1'b0;
    clk(2);
    Reset = 1'b0;
    clk(1);
    check("rmid_busy",     32'(Busy),     32'd0);
    check("rmid_PressCnt", 32'(PressCnt), 32'd0);
    ticks(6);
    check("rmid_n_sym", 32'(n_s + n_l + n_gap + n_ab), 32'd0);
    check("rmid_busy_end", 32'(Busy), 32'd0);

    // Start low mid-press, Start back high with key held, then a fresh press.
    clr();
    Key = 1'b1;
    ticks(2);
    Key = 1'b0;
    clk(1);
    check("st_pre_S", 32'(S), 32'd1);
    ticks(6);
    clr();
    Key = 1'b1;
    ticks(1);
    Start = 1'b0;
    clk(1);
    check("st_busy_low",  32'(Busy),     32'd0);
    ticks(2);
    check("st_PressCnt_kept", 32'(PressCnt), 32'd2);
    Start = 1'b1;
    ticks(3);
    check("st_busy_held", 32'(Busy), 32'd0);
    Key = 1'b0;
    clk(1);
    ticks(6);
    check("st_n_sym", 32'(n_s + n_l + n_gap + n_ab), 32'd0);
    Key = 1'b1;
    ticks(3);
    Key = 1'b0;
    clk(1);
    check("st_L",        32'(L),        32'd1);
    check("st_PressCnt", 32'(PressCnt), 32'd3);
    ticks(6);
    check("st_n_gap", 32'(n_gap), 32'd1);

    check("mutex_pulses", 32'(excl_viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
